axi_ctrl_regfile: RTL
=====================

AXI_CTRL_REGFILE -- requirements
Module: axi_ctrl_regfile

Interface
REQ-001 Parameters SHALL be: name, default, meaning (one per line, REQ-002..REQ-004).
REQ-002 NUM_REGS  4  register count incl. reg 0 (control/status); legal 2..16.
REQ-003 ADDR_W  6  byte-address width; SHALL satisfy 2^(ADDR_W-2) >= NUM_REGS.
REQ-004 PARAM_RESET  all zero  packed (NUM_REGS-1)x32 reset values of param regs 1..NUM_REGS-1.
REQ-005 Ports SHALL be: name  direction  width  meaning (REQ-006..REQ-029).
REQ-006 AXI_CTRL_ACLK  in  1  single clock; all logic on its rising edge.
REQ-007 AXI_CTRL_ARESET  in  1  synchronous, active-high reset.
REQ-008 AXI_CTRL_AWADDR  in  ADDR_W  write byte address.
REQ-009 AXI_CTRL_AWVALID  in  1  write address valid.
REQ-010 AXI_CTRL_AWREADY  out  1  write address ready.
REQ-011 AXI_CTRL_WDATA  in  32  write data.
REQ-012 AXI_CTRL_WSTRB  in  4  byte strobes.
REQ-013 AXI_CTRL_WVALID  in  1  write data valid.
REQ-014 AXI_CTRL_WREADY  out  1  write data ready.
REQ-015 AXI_CTRL_BRESP  out  2  00 OKAY, 10 SLVERR.
REQ-016 AXI_CTRL_BVALID  out  1  write response valid.
REQ-017 AXI_CTRL_BREADY  in  1  write response ready.
REQ-018 AXI_CTRL_ARADDR  in  ADDR_W  read byte address.
REQ-019 AXI_CTRL_ARVALID  in  1  read address valid.
REQ-020 AXI_CTRL_ARREADY  out  1  read address ready.
REQ-021 AXI_CTRL_RDATA  out  32  read data.
REQ-022 AXI_CTRL_RRESP  out  2  00 OKAY, 10 SLVERR.
REQ-023 AXI_CTRL_RVALID  out  1  read data valid.
REQ-024 AXI_CTRL_RREADY  in  1  read data ready.
REQ-025 USER_PARAM  out  (NUM_REGS-1)x32  live values of regs 1..NUM_REGS-1.
REQ-026 USER_GO  out  1  one-cycle start pulse.
REQ-027 USER_BUSY  in  1  user core running.
REQ-028 USER_DONE  in  1  completion event (level or pulse).
REQ-029 USER_IRQ  out  1  DONE & IRQ_EN.

Function
REQ-030 AW and W SHALL be accepted independently into one-entry holding registers; AWREADY/WREADY high only while own holder empty and BVALID low.
REQ-031 Commit SHALL occur the cycle after both holders are full; BVALID rises that cycle and holds until BREADY; holders clear at commit.
REQ-032 Register index = addr[ADDR_W-1:2]; index >= NUM_REGS SHALL give SLVERR with no state change; addr[1:0] ignored.
REQ-033 Regs 1..NUM_REGS-1 SHALL be RW, byte-masked by WSTRB; USER_PARAM updates the cycle after commit.
REQ-034 Reg 0 layout: bit0 GO (WO), bit1 BUSY (RO, =USER_BUSY), bit2 DONE (sticky, W1C), bit3 IRQ_EN (RW); bits 31:4 read 0; writes need WSTRB[0].
REQ-035 Writing GO=1 with USER_BUSY low SHALL pulse USER_GO exactly one cycle, the cycle after commit; with USER_BUSY high it SHALL be dropped, response OKAY.
REQ-036 DONE SHALL set any cycle USER_DONE is high; set wins over simultaneous W1C clear; GO pulse SHALL also clear DONE.
REQ-037 ARREADY SHALL be high while RVALID low; RDATA/RRESP/RVALID registered one cycle after AR handshake; held stable until RREADY.
REQ-038 Out-of-range read SHALL return RDATA 0, RRESP SLVERR.
REQ-039 Read and write to the same register in the same cycle SHALL return the pre-write value.

Reset
REQ-040 While AXI_CTRL_ARESET high: all READY/VALID low, RDATA 0, RESP 00, holders empty, USER_GO 0, DONE 0, IRQ_EN 0, USER_PARAM = PARAM_RESET; reset mid-transaction SHALL abandon it silently.

Structure
REQ-041 Package axi_ctrl_pkg SHALL hold reg-0 bit-index constants and the RESP_OKAY/RESP_SLVERR constants.
REQ-042 Single module; no sub-modules.

Verification
REQ-043 AW at t, W at t+3, addr 0x04, data 0xDEADBEEF, WSTRB 0xF -> BVALID OKAY; USER_PARAM[0]=0xDEADBEEF.
REQ-044 Write 0x0000_00AA, WSTRB 0x1 to 0x08 over value 0x12345678 -> reg reads 0x123456AA.
REQ-045 Write 0x1 to 0x00, USER_BUSY 0 -> USER_GO high exactly one cycle; repeat with USER_BUSY 1 -> no pulse, BRESP 00.
REQ-046 IRQ_EN=1, USER_DONE pulse -> USER_IRQ 1, reg 0 reads 0xC; write 0x4 while USER_DONE high -> DONE stays 1.
REQ-047 NUM_REGS=4, read/write 0x30 -> RRESP/BRESP 10, RDATA 0, no register change.
REQ-048 RREADY held low 5 cycles -> RDATA, RVALID stable, ARREADY low; reset asserted mid-write -> BVALID never rises, params return to PARAM_RESET.

Source files
------------

// File: rtl/axi_ctrl_pkg.sv
// Shared constants and helpers for the AXI-Lite control/parameter register file.
package axi_ctrl_pkg;

  // Bit positions inside register 0 (control/status)
  localparam int REG0_GO_BIT     = 0;
  localparam int REG0_BUSY_BIT   = 1;
  localparam int REG0_DONE_BIT   = 2;
  localparam int REG0_IRQ_EN_BIT = 3;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read image of register 0; GO is write-only and always reads back 0
  function automatic logic [31:0] reg0_word(input logic irq_en, input logic done,
                                            input logic busy);
    logic [31:0] w;
    w                  = '0;
    w[REG0_BUSY_BIT]   = busy;
    w[REG0_DONE_BIT]   = done;
    w[REG0_IRQ_EN_BIT] = irq_en;
    return w;
  endfunction

  // Replace only the bytes of old_word whose strobe bit is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] w;
    w = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/axi_ctrl_regfile.sv
// AXI-Lite slave exposing a control/status register (reg 0) and
// NUM_REGS-1 read/write parameter registers driven out on USER_PARAM.
module axi_ctrl_regfile
  import axi_ctrl_pkg::*;
#(
  parameter int                         NUM_REGS    = 4,
  parameter int                         ADDR_W      = 6,
  parameter logic [(NUM_REGS-1)*32-1:0] PARAM_RESET = '0
) (
  input  logic                         AXI_CTRL_ACLK,
  input  logic                         AXI_CTRL_ARESET,
  input  logic [ADDR_W-1:0]            AXI_CTRL_AWADDR,
  input  logic                         AXI_CTRL_AWVALID,
  output logic                         AXI_CTRL_AWREADY,
  input  logic [31:0]                  AXI_CTRL_WDATA,
  input  logic [3:0]                   AXI_CTRL_WSTRB,
  input  logic                         AXI_CTRL_WVALID,
  output logic                         AXI_CTRL_WREADY,
  output logic [1:0]                   AXI_CTRL_BRESP,
  output logic                         AXI_CTRL_BVALID,
  input  logic                         AXI_CTRL_BREADY,
  input  logic [ADDR_W-1:0]            AXI_CTRL_ARADDR,
  input  logic                         AXI_CTRL_ARVALID,
  output logic                         AXI_CTRL_ARREADY,
  output logic [31:0]                  AXI_CTRL_RDATA,
  output logic [1:0]                   AXI_CTRL_RRESP,
  output logic                         AXI_CTRL_RVALID,
  input  logic                         AXI_CTRL_RREADY,
  output logic [(NUM_REGS-1)*32-1:0]   USER_PARAM,
  output logic                         USER_GO,
  input  logic                         USER_BUSY,
  input  logic                         USER_DONE,
  output logic                         USER_IRQ
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int PW    = (NUM_REGS - 1) * 32;

  // Write-side holding registers
  logic              aw_full_q;
  logic [IDX_W-1:0]  aw_idx_q;
  logic              w_full_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  // Read-side response registers
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  // Architectural state
  logic [PW-1:0]     param_q;
  logic              go_q;
  logic              done_q;
  logic              done_d;
  logic              irq_en_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [31:0]       wr_idx;
  logic [31:0]       rd_idx;
  logic              wr_ok;
  logic              rd_ok;
  logic              reg0_wr;
  logic              go_fire;
  logic [31:0]       rd_word;
  logic              unused_addr_lsbs;

  // Byte offset within a word carries no meaning here
  assign unused_addr_lsbs = ^{AXI_CTRL_AWADDR[1:0], AXI_CTRL_ARADDR[1:0]};

  // Ready terms are gated by reset so the interface is quiet while it is held
  assign AXI_CTRL_AWREADY = ~AXI_CTRL_ARESET & ~aw_full_q & ~bvalid_q;
  assign AXI_CTRL_WREADY  = ~AXI_CTRL_ARESET & ~w_full_q  & ~bvalid_q;
  assign AXI_CTRL_ARREADY = ~AXI_CTRL_ARESET & ~rvalid_q;

  assign aw_hs  = AXI_CTRL_AWVALID & AXI_CTRL_AWREADY;
  assign w_hs   = AXI_CTRL_WVALID  & AXI_CTRL_WREADY;
  assign ar_hs  = AXI_CTRL_ARVALID & AXI_CTRL_ARREADY;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;

  assign wr_idx  = 32'(aw_idx_q);
  assign rd_idx  = 32'(AXI_CTRL_ARADDR[ADDR_W-1:2]);
  assign wr_ok   = wr_idx < 32'(NUM_REGS);
  assign rd_ok   = rd_idx < 32'(NUM_REGS);
  assign reg0_wr = commit & wr_ok & (wr_idx == 32'd0) & w_strb_q[0];
  // GO request while the core is busy is silently dropped
  assign go_fire = reg0_wr & w_data_q[REG0_GO_BIT] & ~USER_BUSY;

  assign AXI_CTRL_BVALID = bvalid_q;
  assign AXI_CTRL_BRESP  = bresp_q;
  assign AXI_CTRL_RVALID = rvalid_q;
  assign AXI_CTRL_RDATA  = rdata_q;
  assign AXI_CTRL_RRESP  = rresp_q;
  assign USER_PARAM      = param_q;
  assign USER_GO         = go_q;
  assign USER_IRQ        = done_q & irq_en_q;

  // Write channel control: holder occupancy and the single outstanding B response
  always_ff @(posedge AXI_CTRL_ACLK) begin
    if (AXI_CTRL_ARESET) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (commit) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) aw_full_q <= 1'b1;
      if (w_hs)  w_full_q  <= 1'b1;
      if (bvalid_q && AXI_CTRL_BREADY) bvalid_q <= 1'b0;
    end
  end

  // Holder payloads; only meaningful while the matching full flag is set
  always_ff @(posedge AXI_CTRL_ACLK) begin
    if (aw_hs) aw_idx_q <= AXI_CTRL_AWADDR[ADDR_W-1:2];
    if (w_hs) begin
      w_data_q <= AXI_CTRL_WDATA;
      w_strb_q <= AXI_CTRL_WSTRB;
    end
  end

  // Parameter registers: byte-masked update on an in-range commit
  always_ff @(posedge AXI_CTRL_ACLK) begin
    if (AXI_CTRL_ARESET) begin
      param_q <= PARAM_RESET;
    end else if (commit && wr_ok) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_idx == 32'(r)) begin
          param_q[(r-1)*32 +: 32] <= byte_merge(param_q[(r-1)*32 +: 32], w_data_q, w_strb_q);
        end
      end
    end
  end

  // Sticky DONE: a completion event wins over W1C and over the GO-triggered clear
  always_comb begin
    done_d = done_q;
    if (go_fire || (reg0_wr && w_data_q[REG0_DONE_BIT])) done_d = 1'b0;
    if (USER_DONE) done_d = 1'b1;
  end

  // Control register state and the one-cycle GO pulse
  always_ff @(posedge AXI_CTRL_ACLK) begin
    if (AXI_CTRL_ARESET) begin
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      go_q   <= go_fire;
      done_q <= done_d;
      if (reg0_wr) irq_en_q <= w_data_q[REG0_IRQ_EN_BIT];
    end
  end

  // Read mux over current state; sampling it at the AR edge yields pre-write data
  always_comb begin
    rd_word = '0;
    if (rd_idx == 32'd0) rd_word = reg0_word(irq_en_q, done_q, USER_BUSY);
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rd_idx == 32'(r)) rd_word = param_q[(r-1)*32 +: 32];
    end
  end

  // Read response register, held until RREADY
  always_ff @(posedge AXI_CTRL_ACLK) begin
    if (AXI_CTRL_ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_ok ? rd_word : 32'h0;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && AXI_CTRL_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule
